// File: rtl/chasy_btn_pkg.sv
// Shared types and 50 MHz default timing for the chasy button conditioner.
package chasy_btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYC      = 500000;    // 10 ms
    localparam int unsigned DEF_REPEAT_DELAY_CYC  = 25000000;  // 500 ms
    localparam int unsigned DEF_REPEAT_PERIOD_CYC = 5000000;   // 100 ms

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chasy_button_ch.sv
// One button channel: synchroniser, debounce FSM, optional auto-repeat.
// Auto-repeat logic is built only when CHASY_BTN_AUTOREPEAT_EN is defined.
module chasy_button_ch
    import chasy_btn_pkg::*;
#(
    parameter bit          ACTIVE_LOW        = 1'b1,
    parameter int unsigned DEBOUNCE_CYC      = DEF_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY_CYC  = DEF_REPEAT_DELAY_CYC,
    parameter int unsigned REPEAT_PERIOD_CYC = DEF_REPEAT_PERIOD_CYC,
    parameter bit          REPEAT_EN         = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press,
    output logic level,
    output logic rel
);

    localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYC);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
        $error("chasy_button_ch: DEBOUNCE_CYC must be >= 2");
    end
    if (REPEAT_EN && (REPEAT_DELAY_CYC < 2 || REPEAT_PERIOD_CYC < 2)) begin : g_bad_repeat
        $error("chasy_button_ch: repeat cycle counts must be >= 2");
    end

    logic          sync1;
    logic          sync2;
    logic          s;
    logic          rep_fire;
    btn_state_t    state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_comb s = sync2 ^ ACTIVE_LOW;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
            level <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= HELD;
                        press <= 1'b1;
                        level <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end else begin
                        press <= rep_fire;
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        rel   <= 1'b1;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CHASY_BTN_AUTOREPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ?
                                   REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
    localparam int unsigned    RW         = cnt_width(RMAX);
    localparam logic [RW-1:0]  DELAY_LAST = RW'(REPEAT_DELAY_CYC - 1);
    localparam logic [RW-1:0]  PER_LAST   = RW'(REPEAT_PERIOD_CYC - 1);

    logic [RW-1:0] rcnt;
    logic          rphase;

    // rphase selects the initial delay (0) or the steady repeat period (1).
    always_comb
        rep_fire = REPEAT_EN && (state == HELD) && s &&
                   (rphase ? (rcnt == PER_LAST) : (rcnt == DELAY_LAST));

    always_ff @(posedge clock) begin
        if (reset || state != HELD || !s || !REPEAT_EN) begin
            rcnt   <= '0;
            rphase <= 1'b0;
        end else if (rep_fire) begin
            rcnt   <= '0;
            rphase <= 1'b1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end
`else
    always_comb rep_fire = 1'b0;
`endif

endmodule

// File: rtl/chasy_button_cond.sv
// Multi-channel push-button conditioner feeding the chasy clock core.
// Define CHASY_BTN_AUTOREPEAT_EN to build auto-repeat for REPEAT_MASK channels.
module chasy_button_cond
    import chasy_btn_pkg::*;
#(
    parameter int unsigned      N_BTN             = 4,
    parameter bit               ACTIVE_LOW        = 1'b1,
    parameter int unsigned      DEBOUNCE_CYC      = DEF_DEBOUNCE_CYC,
    parameter int unsigned      REPEAT_DELAY_CYC  = DEF_REPEAT_DELAY_CYC,
    parameter int unsigned      REPEAT_PERIOD_CYC = DEF_REPEAT_PERIOD_CYC,
    parameter logic [N_BTN-1:0] REPEAT_MASK       = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [0:N_BTN-1] button_raw,
    output logic [0:N_BTN-1] button,
    output logic [0:N_BTN-1] button_level,
    output logic [0:N_BTN-1] button_release
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        chasy_button_ch #(
            .ACTIVE_LOW        (ACTIVE_LOW),
            .DEBOUNCE_CYC      (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC  (REPEAT_DELAY_CYC),
            .REPEAT_PERIOD_CYC (REPEAT_PERIOD_CYC),
            .REPEAT_EN         (REPEAT_MASK[i])
        ) u_ch (
            .clock (clock),
            .reset (reset),
            .raw   (button_raw[i]),
            .press (button[i]),
            .level (button_level[i]),
            .rel   (button_release[i])
        );
    end

endmodule

// File: tb/tb_chasy_button_cond.sv
// Self-checking bench for chasy_button_cond with directed and randomized stimulus.
module tb_chasy_button_cond;

    localparam int unsigned NB  = 4;
    localparam int unsigned DEB = 4;
    localparam int unsigned DLY = 20;
    localparam int unsigned PER = 8;
    localparam logic [NB-1:0] RMASK = 4'b1111;

    logic          clock;
    logic          reset;
    logic [0:NB-1] raw;
    logic [0:NB-1] button;
    logic [0:NB-1] button_level;
    logic [0:NB-1] button_release;

    int total;
    int bad;
    int cyc;

    chasy_button_cond #(
        .N_BTN             (NB),
        .ACTIVE_LOW        (1'b1),
        .DEBOUNCE_CYC      (DEB),
        .REPEAT_DELAY_CYC  (DLY),
        .REPEAT_PERIOD_CYC (PER),
        .REPEAT_MASK       (RMASK)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .button_raw     (raw),
        .button         (button),
        .button_level   (button_level),
        .button_release (button_release)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: the level flips once the pressed-ness seen two edges after
    // the pin differs from it for DEB+1 consecutive edges; hold time is
    // counted in whole cycles of uninterrupted accepted press.
    bit            h1 [NB];
    bit            h2 [NB];
    bit            mlvl [NB];
    int            run [NB];
    int            held [NB];
    bit            m_vis;
    bit            m_was;
    logic [0:NB-1] e_btn;
    logic [0:NB-1] e_lvl;
    logic [0:NB-1] e_rel;

    always @(posedge clock) begin
        cyc++;
        for (int ch = 0; ch < NB; ch++) begin
            if (reset) begin
                h1[ch] = 0; h2[ch] = 0; mlvl[ch] = 0; run[ch] = 0; held[ch] = 0;
                e_btn[ch] = 0; e_rel[ch] = 0; e_lvl[ch] = 0;
            end else begin
                m_vis  = h2[ch];
                h2[ch] = h1[ch];
                h1[ch] = (raw[ch] == 1'b0);
                m_was  = mlvl[ch] && (run[ch] == 0);
                e_btn[ch] = 0;
                e_rel[ch] = 0;
                if (m_vis != mlvl[ch]) run[ch]++;
                else run[ch] = 0;
                if (run[ch] == DEB + 1) begin
                    mlvl[ch] = m_vis;
                    run[ch]  = 0;
                    if (m_vis) e_btn[ch] = 1;
                    else e_rel[ch] = 1;
                end
`ifdef CHASY_BTN_AUTOREPEAT_EN
                if (m_was && m_vis && RMASK[ch]) begin
                    held[ch]++;
                    if (held[ch] == DLY || (held[ch] > DLY && (held[ch] - DLY) % PER == 0))
                        e_btn[ch] = 1;
                end else begin
                    held[ch] = 0;
                end
`else
                held[ch] = m_was ? held[ch] + 1 : 0;
`endif
                e_lvl[ch] = mlvl[ch];
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        raw   = '1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int k;
        reset = 1'b1;
        raw   = '1;
        tick();
        tick();
        total++;
        if ({button, button_level, button_release} !== '0) begin
            bad++;
            $display("FAIL reset_during got=%b/%b/%b want=0", button, button_level, button_release);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({button, button_level, button_release} !== '0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%b/%b/%b want=0", cyc, button, button_level, button_release);
            end
        end
        raw[0] = 1'b0;
        k = cyc + 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (button[0] !== (cyc == k + 6)) begin
                bad++;
                $display("FAIL press_latency cyc=%0d got=%b want=%b", cyc, button[0], cyc == k + 6);
            end
            total++;
            if (button_level[0] !== (cyc >= k + 6)) begin
                bad++;
                $display("FAIL press_level cyc=%0d got=%b want=%b", cyc, button_level[0], cyc >= k + 6);
            end
        end
    endtask

    task automatic test_bounce();
        int pat [4] = '{3, 2, 2, 13};
        do_reset();
        for (int p = 0; p < 4; p++) begin
            raw[1] = (p % 2 == 1) || (p == 3);
            for (int i = 0; i < pat[p]; i++) begin
                tick();
                total++;
                if ({button[1], button_level[1], button_release[1]} !== 3'b000) begin
                    bad++;
                    $display("FAIL bounce cyc=%0d got=%b%b%b want=000", cyc, button[1], button_level[1], button_release[1]);
                end
            end
        end
    endtask

    task automatic test_release();
        int r;
        int pulses;
        do_reset();
        pulses = 0;
        raw[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            pulses += int'(button[2]);
        end
        raw[2] = 1'b1;
        r = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            pulses += int'(button[2]);
            total++;
            if (button_release[2] !== (cyc == r + 6)) begin
                bad++;
                $display("FAIL release_pulse cyc=%0d got=%b want=%b", cyc, button_release[2], cyc == r + 6);
            end
            total++;
            if (button_level[2] !== (cyc < r + 6)) begin
                bad++;
                $display("FAIL release_level cyc=%0d got=%b want=%b", cyc, button_level[2], cyc < r + 6);
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL release_press_count got=%0d want=1", pulses);
        end
    endtask

    task automatic test_simultaneous();
        int k;
        logic [0:NB-1] want;
        do_reset();
        raw[0] = 1'b0;
        raw[3] = 1'b0;
        k = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            want = (cyc == k + 6) ? 4'b1001 : 4'b0000;
            total++;
            if (button !== want) begin
                bad++;
                $display("FAIL simul_btn cyc=%0d got=%b want=%b", cyc, button, want);
            end
            total++;
            if ({button_level[1], button_level[2], button_release[1], button_release[2]} !== 4'b0000) begin
                bad++;
                $display("FAIL simul_other cyc=%0d got=%b want=0000", cyc,
                         {button_level[1], button_level[2], button_release[1], button_release[2]});
            end
        end
    endtask

    task automatic test_autorepeat();
        int h;
        int offs [$];
        int want [$];
        do_reset();
        h = -1;
        raw[1] = 1'b0;
        for (int i = 0; i < 20 && h < 0; i++) begin
            tick();
            if (button[1]) h = cyc;
        end
        total++;
        if (h < 0) begin
            bad++;
            $display("FAIL repeat_first_press got=none want=pulse within 20 cycles");
        end else begin
            offs.push_back(0);
            while (cyc < h + 55) begin
                tick();
                if (button[1]) offs.push_back(cyc - h);
            end
            raw[1] = 1'b1;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (button[1]) offs.push_back(cyc - h);
            end
`ifdef CHASY_BTN_AUTOREPEAT_EN
            want = '{0, 20, 28, 36, 44, 52};
`else
            want = '{0};
`endif
            if (offs.size() != want.size()) begin
                bad++;
                $display("FAIL repeat_count got=%0d want=%0d", offs.size(), want.size());
            end else begin
                for (int i = 0; i < want.size(); i++) begin
                    total++;
                    if (offs[i] != want[i]) begin
                        bad++;
                        $display("FAIL repeat_offset idx=%0d got=%0d want=%0d", i, offs[i], want[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        int d;
        do_reset();
        raw[0] = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (button !== '0) begin
                bad++;
                $display("FAIL abort_in_reset cyc=%0d got=%b want=0000", cyc, button);
            end
        end
        reset = 1'b0;
        d = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (button[0] !== (cyc == d + 6)) begin
                bad++;
                $display("FAIL abort_repress cyc=%0d got=%b want=%b", cyc, button[0], cyc == d + 6);
            end
        end
    endtask

    task automatic test_random();
        int dur [NB];
        do_reset();
        for (int ch = 0; ch < NB; ch++) dur[ch] = $urandom_range(1, 8);
        for (int n = 0; n < 1500; n++) begin
            for (int ch = 0; ch < NB; ch++) begin
                if (dur[ch] == 0) begin
                    raw[ch] = ~raw[ch];
                    dur[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 60) : $urandom_range(1, 8);
                end else begin
                    dur[ch]--;
                end
            end
            reset = ($urandom_range(0, 399) == 0);
            tick();
            total++;
            if (button !== e_btn || button_level !== e_lvl || button_release !== e_rel) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b/%b/%b want=%b/%b/%b", cyc,
                         button, button_level, button_release, e_btn, e_lvl, e_rel);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        reset = 1'b1;
        raw   = '1;
        test_reset();
        test_bounce();
        test_release();
        test_simultaneous();
        test_autorepeat();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
